mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
MEM-stage initiator for the word-addressed data memory. It takes one load/store request at a time from the pipeline and drives the DM port (A, WData, MemRead, MemWrite, WriteBE, PC). Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write, because the DM zeroes byte lanes that are not enabled. The pipeline stalls while `req_ready` is low.

Parameters:
- ADDR_W, 12, DM word-index width; the DM holds 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address that maps to DM word 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- req_pc  in  32  PC of the instruction
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned or out-of-range access; qualified by resp_valid
- A  out  ADDR_W  DM word index
- WData  out  32  DM write data
- MemRead  out  1  DM read enable
- MemWrite  out  1  DM write enable
- WriteBE  out  4  DM byte enables
- PC  out  32  latched req_pc, passed to the DM

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset (including mid-operation): state goes to IDLE and the latched request is dropped.
  - All outputs are 0 except req_ready, which is 1.
  - MemWrite is never asserted in the reset cycle or the cycle after it.
- Accept: in IDLE, req_valid && req_ready latches op, addr, wdata and pc. No DM signals are driven in the accept cycle.
- Offset: off = addr − BASE_ADDR. Word index A = off[ADDR_W+1:2].
- Error check (at accept):
  - Error if off[31:ADDR_W+2] != 0.
  - Error if a W op has off[1:0] != 0.
  - Error if an H op has off[0] != 0.
- Byte order is little-endian.
  - Byte k (= off[1:0]) occupies bits [8k+7:8k].
  - Halfword h (= off[1]) occupies bits [16h+15:16h].
- States:
  - IDLE: req_ready=1. On accept, go to ERR, LD, ST or RMW_RD.
  - ERR: no DM access. Go to DONE with err=1, data=0.
  - LD: MemRead=1, A valid. Capture the extracted, extended RD into the resp register. Go to DONE.
    - LH/LB sign-extend; LHU/LBU zero-extend.
  - ST: MemWrite=1, WriteBE=4'b1111, WData=wdata. Go to DONE.
  - RMW_RD: MemRead=1. Latch merged = RD with the target byte/half replaced by wdata[7:0] or [15:0]. Go to RMW_WR.
  - RMW_WR: MemWrite=1, WriteBE=4'b1111, WData=merged, same A. Go to DONE.
  - DONE: resp_valid=1 for exactly one cycle with registered resp_data and resp_err. Go to IDLE.
- Outside the states that use them, MemRead, MemWrite and WriteBE are 0, and A/WData hold their last value.
- Latency, accept cycle to resp_valid: LW/LH/LB/SW = 2 cycles; SH/SB = 3; error = 2.
- PC output holds the latched pc from accept until the next accept.
- req_valid is ignored outside IDLE. The requester must hold the request until req_ready.
- No merging or back-to-back accept: the next request is accepted at the earliest in the cycle after DONE.

Decomposition:
- Shared package `mem_pkg`:
  - op encodings (OP_LW … OP_SB)
  - state encoding
  - BE_ALL = 4'b1111
- One sub-module, `mem_lane_ext`, is combinational. Given (word, off[1:0], op) it produces:
  - the extended load value
  - the merged store word, given wdata

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF → A=4, WriteBE=1111, MemWrite one cycle. Then LW 0x10 → resp_data=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- With word 4 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE
  - LBU 0x13 → 0x000000DE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x10 → 0x0000BEEF
- SB 0x11 data 0x55 on word 0xDEADBEEF → RMW_RD then RMW_WR with WData=0xDEAD55EF. A following LW 0x10 returns 0xDEAD55EF. SH 0x12 data 0x1234 → 0x123455EF.
- Errors: LW 0x11, SH 0x13, and SW 0x4000 (ADDR_W=12) each give resp_err=1 and resp_data=0. MemRead and MemWrite stay 0 throughout.
- Reset asserted during RMW_RD of an SB → no MemWrite pulse, IDLE and req_ready=1 next cycle, no resp_valid.
- req_valid held high with a second request during a busy SH → the second request is accepted only in the cycle after DONE; its pc appears on PC only after that accept.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory initiator.
//   - mem_op_e : load/store operation encodings carried on req_op
//   - state_e  : controller FSM states
//   - BE_ALL   : full-word byte enable
//   - helpers  : operation classification used by the error check and FSM
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ERR    = 3'd1,
        S_LD     = 3'd2,
        S_ST     = 3'd3,
        S_RMW_RD = 3'd4,
        S_RMW_WR = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic is_load(input mem_op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_word(input mem_op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input mem_op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// mem_lane_ext: combinational byte-lane logic (little-endian).
//   word     in  32  word read from the data memory
//   byte_off in   2  byte offset within the word
//   op       in   3  operation (mem_op_e)
//   wdata    in  32  store data (SH uses [15:0], SB uses [7:0])
//   load_val out 32  extracted and sign/zero-extended load value
//   merged   out 32  word with the addressed byte/half replaced by wdata
module mem_lane_ext
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  mem_op_e     op,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        shifted  = word >> {byte_off, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = byte_off[1] ? word[31:16] : word[15:0];
        load_val = '0;
        merged   = word;

        unique case (op)
            OP_LW:   load_val = word;
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = '0;
        endcase

        if (op == OP_SB) begin
            merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
        end else if (op == OP_SH) begin
            merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for the word-addressed data memory.
// Accepts one load/store at a time, drives the DM port, extends sub-word
// loads and performs sub-word stores as read-modify-write (the DM zeroes
// byte lanes that are not enabled).
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/addr/wdata/pc  request fields
//   resp_valid/data/err   one-cycle completion pulse with result
//   A, WData, MemRead, MemWrite, WriteBE, PC   DM port outputs
//   RD                    DM read data, combinational on A
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WData,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [3:0]        WriteBE,
    output logic [31:0]       PC,
    input  logic [31:0]       RD
);

    state_e            state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [1:0]        boff_q, boff_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [3:0]        be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    mem_op_e     req_op_e;
    logic [31:0] off;
    logic        acc_err;
    logic [31:0] load_val;
    logic [31:0] merged;

    mem_lane_ext u_lane (
        .word     (RD),
        .byte_off (boff_q),
        .op       (op_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        req_op_e = mem_op_e'(req_op);
        off      = req_addr - BASE_ADDR;
        acc_err  = ((off >> (ADDR_W + 2)) != 32'd0) ||
                   (is_word(req_op_e) && (off[1:0] != 2'b00)) ||
                   (is_half(req_op_e) && off[0]);

        state_d      = state_q;
        op_d         = op_q;
        boff_d       = boff_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        a_d          = a_q;
        dm_wdata_d   = dm_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        be_d         = 4'b0000;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op_e;
                    boff_d      = off[1:0];
                    wdata_d     = req_wdata;
                    pc_d        = req_pc;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (acc_err) begin
                        state_d = S_ERR;
                    end else begin
                        a_d = off[ADDR_W+1:2];
                        if (is_load(req_op_e)) begin
                            state_d    = S_LD;
                            mem_read_d = 1'b1;
                        end else if (req_op_e == OP_SW) begin
                            state_d     = S_ST;
                            mem_write_d = 1'b1;
                            be_d        = BE_ALL;
                            dm_wdata_d  = req_wdata;
                        end else begin
                            state_d    = S_RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_ERR: begin
                state_d     = S_DONE;
                resp_err_d  = 1'b1;
                resp_data_d = '0;
            end
            S_LD: begin
                state_d     = S_DONE;
                resp_data_d = load_val;
            end
            S_RMW_RD: begin
                // The merged word goes straight into the write-data register
                // so it is stable for the whole RMW_WR cycle.
                state_d     = S_RMW_WR;
                dm_wdata_d  = merged;
                mem_write_d = 1'b1;
                be_d        = BE_ALL;
            end
            S_ST, S_RMW_WR: state_d = S_DONE;
            S_DONE:         state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LW;
            boff_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            a_q          <= '0;
            dm_wdata_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            be_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            boff_q       <= boff_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            dm_wdata_q   <= dm_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign A          = a_q;
    assign WData      = dm_wdata_q;
    assign MemRead    = mem_read_q;
    // Reset suppresses a write already registered for the cycle in which
    // reset is asserted, so an aborted store never reaches the DM.
    assign MemWrite   = mem_write_q & ~reset;
    assign WriteBE    = be_q;
    assign PC         = pc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr, req_wdata, req_pc;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] A;
    logic [31:0]       WData;
    logic              MemRead, MemWrite;
    logic [3:0]        WriteBE;
    logic [31:0]       PC;
    logic [31:0]       RD;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mem_access_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .A(A), .WData(WData), .MemRead(MemRead), .MemWrite(MemWrite),
        .WriteBE(WriteBE), .PC(PC), .RD(RD)
    );

    always #5 clk = ~clk;

    // DM model: combinational read, lanes not enabled are written as zero.
    assign RD = mem[A];
    always @(posedge clk) begin
        if (MemWrite) begin
            for (int b = 0; b < 4; b++)
                mem[A][8*b +: 8] <= WriteBE[b] ? WData[8*b +: 8] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                          input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata,
                          input logic [ADDR_W-1:0] exp_a);
        exp_t e;
        int n, rd_cnt, wr_cnt, wait_n;
        logic [31:0] w_data;
        logic [ADDR_W-1:0] acc_a;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
        e.data = exp_data; e.err = exp_err;
        sb_q.push_back(e);
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        n = 0; got = 0; rd_cnt = 0; wr_cnt = 0; w_data = '0; acc_a = '0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (i == 1) check({tag, " pc"}, PC, pc);
            if (MemRead) begin rd_cnt++; acc_a = A; end
            if (MemWrite) begin
                wr_cnt++; w_data = WData; acc_a = A;
                check({tag, " be"}, 32'(WriteBE), 32'hF);
            end
            if (resp_valid) begin got = 1; n = i; end
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        if (got && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " data"}, resp_data, e.data);
            check({tag, " err"}, 32'(resp_err), 32'(e.err));
        end
        check({tag, " reads"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, " writes"}, 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr > 0) check({tag, " wdata"}, w_data, exp_wdata);
        if (exp_rd + exp_wr > 0) check({tag, " addr"}, 32'(acc_a), 32'(exp_a));
        @(negedge clk);
        check({tag, " valid pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        reset = 1'b1; req_valid = 1'b0; req_op = '0;
        req_addr = '0; req_wdata = '0; req_pc = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst ready",  32'(req_ready), 32'd1);
        check("rst valid",  32'(resp_valid), 32'd0);
        check("rst memrd",  32'(MemRead), 32'd0);
        check("rst memwr",  32'(MemWrite), 32'd0);
        check("rst be",     32'(WriteBE), 32'd0);
        check("rst a",      32'(A), 32'd0);
        check("rst pc",     PC, 32'd0);
        check("rst data",   resp_data, 32'd0);
        reset = 1'b0;

        // Word store/load and sub-word loads on word 4 = DEADBEEF
        do_req("sw",  3'd5, 32'h10, 32'hDEADBEEF, 32'h1000, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 12'd4);
        do_req("lw",  3'd0, 32'h10, 32'h0,        32'h1004, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, 12'd4);
        do_req("lb",  3'd3, 32'h13, 32'h0,        32'h1008, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0, 12'd4);
        do_req("lbu", 3'd4, 32'h13, 32'h0,        32'h100C, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0, 12'd4);
        do_req("lh",  3'd1, 32'h12, 32'h0,        32'h1010, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0, 12'd4);
        do_req("lhu", 3'd2, 32'h10, 32'h0,        32'h1014, 32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0, 12'd4);

        // Read-modify-write stores
        do_req("sb",  3'd7, 32'h11, 32'h00000055, 32'h1018, 32'h0, 1'b0, 3, 1, 1, 32'hDEAD55EF, 12'd4);
        do_req("lw2", 3'd0, 32'h10, 32'h0,        32'h101C, 32'hDEAD55EF, 1'b0, 2, 1, 0, 32'h0, 12'd4);
        do_req("sh",  3'd6, 32'h12, 32'h00001234, 32'h1020, 32'h0, 1'b0, 3, 1, 1, 32'h123455EF, 12'd4);
        do_req("lw3", 3'd0, 32'h10, 32'h0,        32'h1024, 32'h123455EF, 1'b0, 2, 1, 0, 32'h0, 12'd4);

        // Highest valid byte address, then errors
        do_req("lbu top", 3'd4, 32'h3FFF, 32'h0,  32'h1028, 32'h0, 1'b0, 2, 1, 0, 32'h0, 12'hFFF);
        do_req("err lw",  3'd0, 32'h11,   32'h0,  32'h102C, 32'h0, 1'b1, 2, 0, 0, 32'h0, 12'd0);
        do_req("err sh",  3'd6, 32'h13,   32'h99, 32'h1030, 32'h0, 1'b1, 2, 0, 0, 32'h0, 12'd0);
        do_req("err sw",  3'd5, 32'h4000, 32'h99, 32'h1034, 32'h0, 1'b1, 2, 0, 0, 32'h0, 12'd0);

        // Reset during RMW_RD of an SB
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h10; req_wdata = 32'h77; req_pc = 32'h2000;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort in rmw_rd", 32'(MemRead), 32'd1);
        reset = 1'b1;
        #1 check("abort wr reset cyc", 32'(MemWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("abort wr after",  32'(MemWrite), 32'd0);
        check("abort ready",     32'(req_ready), 32'd1);
        check("abort valid",     32'(resp_valid), 32'd0);
        check("abort pc",        PC, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort quiet wr",    32'(MemWrite), 32'd0);
            check("abort quiet valid", 32'(resp_valid), 32'd0);
        end
        do_req("lw abort", 3'd0, 32'h10, 32'h0, 32'h2004, 32'h123455EF, 1'b0, 2, 1, 0, 32'h0, 12'd4);

        // Second request held during a busy SH
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h12; req_wdata = 32'hABCD; req_pc = 32'h3000;
        @(negedge clk);
        req_op = 3'd0; req_addr = 32'h10; req_wdata = 32'h0; req_pc = 32'h3004;
        sb_q.push_back('{data: 32'h0, err: 1'b0});
        sb_q.push_back('{data: 32'hABCD55EF, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            check("b2b busy ready", 32'(req_ready), 32'd0);
            check("b2b busy pc", PC, 32'h3000);
            if (i == 2) begin
                check("b2b sh valid", 32'(resp_valid), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_t e0;
                    e0 = sb_q.pop_front();
                    check("b2b sh data", resp_data, e0.data);
                end
            end
            @(negedge clk);
        end
        check("b2b idle ready", 32'(req_ready), 32'd1);
        check("b2b pc before accept", PC, 32'h3000);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b pc after accept", PC, 32'h3004);
        check("b2b lw read", 32'(MemRead), 32'd1);
        @(negedge clk);
        check("b2b lw valid", 32'(resp_valid), 32'd1);
        if (sb_q.size() > 0) begin
            exp_t e1;
            e1 = sb_q.pop_front();
            check("b2b lw data", resp_data, e1.data);
            check("b2b lw err", 32'(resp_err), 32'(e1.err));
        end
        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
